// File: rtl/idu_pkg.sv
// Shared definitions for the instruction-decode stage: RV32I/RV64I opcode,
// funct3 and funct7 constants, ALU / operand-select / memory-size encodings,
// the decoded control bundle and the stage FSM state type.
// No ports (package).
package idu_pkg;

    // Base opcodes
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // funct3 values that need special legality handling
    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SLL = 3'd1;
    localparam logic [2:0] F3_SR  = 3'd5;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LWU = 3'd6;
    localparam logic [2:0] F3_SD  = 3'd3;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Second-operand select
    localparam logic [1:0] SRC_REG     = 2'd0;
    localparam logic [1:0] SRC_IMM     = 2'd1;
    localparam logic [1:0] SRC_IMM_PC  = 2'd2;
    localparam logic [1:0] SRC_FOUR_PC = 2'd3;

    // Memory access size
    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;
    localparam logic [1:0] MEM_D = 2'd3;

    // Immediate is kept at 64 bits; narrower builds use the low XLEN bits,
    // which are identical to an XLEN-wide sign extension.
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] imm;
        logic [3:0]  alu_op;
        logic [1:0]  src_sel;
        logic        branch;
        logic [2:0]  br_cond;
        logic        jump;
        logic        jalr;
        logic        mem_ren;
        logic        mem_wen;
        logic [1:0]  mem_size;
        logic        mem_uns;
        logic        word;
        logic        illegal;
        logic        ebreak;
    } dec_t;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    // Register/immediate ALU op from funct3; alt selects SUB/SRA.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idu_decode.sv
// Combinational RV32I/RV64I decoder: instruction word -> control bundle.
// Ports:
//   inst  in   32-bit instruction word
//   dec   out  decoded bundle (dec_t); illegal encodings give an all-zero
//              bundle with only the illegal flag set
module idu_decode
    import idu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0] inst,
    output dec_t        dec
);

    localparam bit Rv64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        shamt_hi_bad;
    logic        illegal;
    logic        word;
    dec_t        d;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign imm_i = {{52{inst[31]}}, inst[31:20]};
    assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // shamt[5] only exists on RV64
    assign shamt_hi_bad = !Rv64 && inst[25];

    always_comb begin
        d       = '0;
        illegal = 1'b0;
        word    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d.rd = rd; d.rd_wen = 1'b1; d.imm = imm_u; d.src_sel = SRC_IMM;
            end
            OPC_AUIPC: begin
                d.rd = rd; d.rd_wen = 1'b1; d.imm = imm_u; d.src_sel = SRC_IMM_PC;
            end
            OPC_JAL: begin
                d.rd = rd; d.rd_wen = 1'b1; d.imm = imm_j; d.jump = 1'b1;
                d.src_sel = SRC_FOUR_PC;
            end
            OPC_JALR: begin
                illegal = (funct3 != 3'd0);
                d.rs1 = rs1; d.rd = rd; d.rd_wen = 1'b1; d.imm = imm_i; d.jalr = 1'b1;
                d.src_sel = SRC_FOUR_PC;
            end
            OPC_BRANCH: begin
                illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
                d.rs1 = rs1; d.rs2 = rs2; d.imm = imm_b; d.branch = 1'b1; d.br_cond = funct3;
            end
            OPC_LOAD: begin
                illegal = (funct3 == 3'd7) || (!Rv64 && (funct3 == F3_LD || funct3 == F3_LWU));
                d.rs1 = rs1; d.rd = rd; d.rd_wen = 1'b1; d.imm = imm_i; d.src_sel = SRC_IMM;
                d.mem_ren = 1'b1; d.mem_size = funct3[1:0]; d.mem_uns = funct3[2];
            end
            OPC_STORE: begin
                illegal = funct3[2] || (!Rv64 && funct3 == F3_SD);
                d.rs1 = rs1; d.rs2 = rs2; d.imm = imm_s; d.src_sel = SRC_IMM;
                d.mem_wen = 1'b1; d.mem_size = funct3[1:0];
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                word = (opcode == OPC_OP_IMM_32);
                d.rs1 = rs1; d.rd = rd; d.rd_wen = 1'b1; d.imm = imm_i; d.src_sel = SRC_IMM;
                d.word = word;
                d.alu_op = alu_from_funct3(funct3, inst[30] && (funct3 == F3_SR));
                if (word && !Rv64) illegal = 1'b1;
                if (word && !(funct3 inside {F3_ADD, F3_SLL, F3_SR})) illegal = 1'b1;
                if (funct3 == F3_SLL) begin
                    illegal |= word ? (funct7 != F7_BASE)
                                    : ((inst[31:26] != 6'h00) || shamt_hi_bad);
                end
                if (funct3 == F3_SR) begin
                    illegal |= word ? !(funct7 inside {F7_BASE, F7_ALT})
                                    : (!(inst[31:26] inside {6'h00, 6'h10}) || shamt_hi_bad);
                end
            end
            OPC_OP, OPC_OP_32: begin
                word = (opcode == OPC_OP_32);
                d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.rd_wen = 1'b1; d.src_sel = SRC_REG;
                d.word = word;
                d.alu_op = alu_from_funct3(funct3, funct7 == F7_ALT);
                if (word && !Rv64) illegal = 1'b1;
                if (word && !(funct3 inside {F3_ADD, F3_SLL, F3_SR})) illegal = 1'b1;
                if (!((funct7 == F7_BASE) ||
                      (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)))) begin
                    illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // fence behaves as a no-op in this in-order pipeline
                illegal = (funct3 != 3'd0);
            end
            OPC_SYSTEM: begin
                illegal  = (inst != INST_ECALL) && (inst != INST_EBREAK);
                d.ebreak = (inst == INST_EBREAK);
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        if (d.rd == 5'd0) d.rd_wen = 1'b0;
        dec = d;
    end

endmodule

// File: rtl/idu_stage.sv
// Registered instruction-decode stage between IFU and EXU.
// Decodes on the input path, then holds bundles in an output register plus a
// one-entry skid register. flush drops both; an accepted ebreak moves the
// stage to HALT, which only rst leaves.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     drop all buffered bundles, accept nothing
//   in_valid/in_ready         IFU handshake; in_inst, in_pc payload
//   out_valid/out_ready       EXU handshake; out_* decoded bundle
//   halted                    stage is in HALT
module idu_stage
    import idu_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic                out_rd_wen,
    output logic [XLEN-1:0]     out_imm,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [1:0]          out_src_sel,
    output logic                out_branch,
    output logic [2:0]          out_br_cond,
    output logic                out_jump,
    output logic                out_jalr,
    output logic                out_mem_ren,
    output logic                out_mem_wen,
    output logic [1:0]          out_mem_size,
    output logic                out_mem_uns,
    output logic                out_word,
    output logic                out_illegal,
    output logic                out_ebreak,
    output logic                halted
);

    dec_t            dec;
    dec_t            out_q, out_d, skid_q, skid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    state_e          state_q, state_d;
    logic            accept;

    idu_decode #(.XLEN(XLEN)) u_decode (
        .inst (in_inst),
        .dec  (dec)
    );

    assign halted   = (state_q == StHalt);
    assign in_ready = !skid_valid_q && !halted && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_d        = out_q;
        out_pc_d     = out_pc_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        state_d      = state_q;

        if (accept && dec.ebreak) state_d = StHalt;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output register frees up: skid first to keep order. in_ready is
            // low whenever skid is valid, so both cannot load at once.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_pc_d     = skid_pc_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_pc_d    = in_pc;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_pc_d    = in_pc;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_pc_q     <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            state_q      <= StRun;
        end else begin
            out_q        <= out_d;
            out_pc_q     <= out_pc_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            state_q      <= state_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_rd       = out_q.rd;
    assign out_rd_wen   = out_q.rd_wen;
    assign out_imm      = out_q.imm[XLEN-1:0];
    assign out_alu_op   = ALU_OP_W'(out_q.alu_op);
    assign out_src_sel  = out_q.src_sel;
    assign out_branch   = out_q.branch;
    assign out_br_cond  = out_q.br_cond;
    assign out_jump     = out_q.jump;
    assign out_jalr     = out_q.jalr;
    assign out_mem_ren  = out_q.mem_ren;
    assign out_mem_wen  = out_q.mem_wen;
    assign out_mem_size = out_q.mem_size;
    assign out_mem_uns  = out_q.mem_uns;
    assign out_word     = out_q.word;
    assign out_illegal  = out_q.illegal;
    assign out_ebreak   = out_q.ebreak;

endmodule

// File: tb/tb_idu_stage.sv
module tb_idu_stage;
    import idu_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_wen;
        logic [63:0] imm;
        logic [3:0]  alu;
        logic [1:0]  src;
        logic        br;
        logic [2:0]  brc;
        logic        jmp, jalr, ren, wen;
        logic [1:0]  size;
        logic        uns, word, ill, ebk;
    } bund_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = 32'h0;
    logic [63:0] in_pc = 64'h0;
    logic [31:0] in_pc_b;
    assign in_pc_b = in_pc[31:0];

    // a_*: XLEN=64 instance, b_*: XLEN=32 instance, same stimulus
    logic        a_rdy, a_ov, a_rd_wen, a_br, a_jmp, a_jalr, a_ren, a_wen, a_uns, a_word;
    logic        a_ill, a_ebk, a_halt;
    logic [63:0] a_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [3:0]  a_alu;
    logic [1:0]  a_src, a_size;
    logic [2:0]  a_brc;
    logic        b_rdy, b_ov, b_rd_wen, b_br, b_jmp, b_jalr, b_ren, b_wen, b_uns, b_word;
    logic        b_ill, b_ebk, b_halt;
    logic [31:0] b_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [3:0]  b_alu;
    logic [1:0]  b_src, b_size;
    logic [2:0]  b_brc;

    idu_stage #(.XLEN(64), .ALU_OP_W(4)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_ov), .out_ready(out_ready),
        .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
        .out_rd_wen(a_rd_wen), .out_imm(a_imm), .out_alu_op(a_alu), .out_src_sel(a_src),
        .out_branch(a_br), .out_br_cond(a_brc), .out_jump(a_jmp), .out_jalr(a_jalr),
        .out_mem_ren(a_ren), .out_mem_wen(a_wen), .out_mem_size(a_size),
        .out_mem_uns(a_uns), .out_word(a_word), .out_illegal(a_ill), .out_ebreak(a_ebk),
        .halted(a_halt)
    );

    idu_stage #(.XLEN(32), .ALU_OP_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
        .in_inst(in_inst), .in_pc(in_pc_b), .out_valid(b_ov), .out_ready(out_ready),
        .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
        .out_rd_wen(b_rd_wen), .out_imm(b_imm), .out_alu_op(b_alu), .out_src_sel(b_src),
        .out_branch(b_br), .out_br_cond(b_brc), .out_jump(b_jmp), .out_jalr(b_jalr),
        .out_mem_ren(b_ren), .out_mem_wen(b_wen), .out_mem_size(b_size),
        .out_mem_uns(b_uns), .out_word(b_word), .out_illegal(b_ill), .out_ebreak(b_ebk),
        .halted(b_halt)
    );

    bund_t obs_a, obs_b;
    assign obs_a = {a_pc, a_rs1, a_rs2, a_rd, a_rd_wen, a_imm, a_alu, a_src, a_br, a_brc,
                    a_jmp, a_jalr, a_ren, a_wen, a_size, a_uns, a_word, a_ill, a_ebk};
    assign obs_b = {32'b0, b_pc, b_rs1, b_rs2, b_rd, b_rd_wen, 32'b0, b_imm, b_alu, b_src,
                    b_br, b_brc, b_jmp, b_jalr, b_ren, b_wen, b_size, b_uns, b_word, b_ill,
                    b_ebk};

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    ent_t q[$];
    bit   m_halt = 1'b0;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SUB  = 32'h4020_8133;
    localparam logic [31:0] I_SD   = 32'h0020_B423;
    localparam logic [31:0] I_LD   = 32'h0000_B083;
    localparam logic [31:0] I_EBRK = 32'h0010_0073;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input bund_t obs, input bund_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the RV32I/RV64I encoding rules.
    function automatic bund_t ref_dec(input logic [31:0] i, input bit rv64);
        bund_t       e;
        bit          ok, wd;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [63:0] ii, is, ib, iu, ij;
        logic [3:0]  tab [8];
        tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        e = '0; ok = 1'b1;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        ii = {{52{i[31]}}, i[31:20]};
        is = {{52{i[31]}}, i[31:25], i[11:7]};
        ib = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        iu = {{32{i[31]}}, i[31:12], 12'b0};
        ij = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        wd = (op == 7'h1b) || (op == 7'h3b);
        case (op)
            7'h37: begin e.rd = i[11:7]; e.rd_wen = 1; e.imm = iu; e.src = SRC_IMM; end
            7'h17: begin e.rd = i[11:7]; e.rd_wen = 1; e.imm = iu; e.src = SRC_IMM_PC; end
            7'h6f: begin
                e.rd = i[11:7]; e.rd_wen = 1; e.imm = ij; e.jmp = 1; e.src = SRC_FOUR_PC;
            end
            7'h67: begin
                ok = (f3 == 0);
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.rd_wen = 1; e.imm = ii; e.jalr = 1;
                e.src = SRC_FOUR_PC;
            end
            7'h63: begin
                ok = (f3 != 2) && (f3 != 3);
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = ib; e.br = 1; e.brc = f3;
            end
            7'h03: begin
                ok = rv64 ? (f3 != 7) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.rd_wen = 1; e.imm = ii; e.src = SRC_IMM;
                e.ren = 1; e.size = f3[1:0]; e.uns = f3[2];
            end
            7'h23: begin
                ok = (f3 <= 2) || (rv64 && f3 == 3);
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = is; e.src = SRC_IMM;
                e.wen = 1; e.size = f3[1:0];
            end
            7'h13, 7'h1b: begin
                ok = !wd || rv64;
                if (wd) ok = ok && (f3 inside {3'd0, 3'd1, 3'd5});
                if (f3 == 1) ok = ok && (wd ? (f7 == 0) : (i[31:26] == 0 && (rv64 || !i[25])));
                if (f3 == 5) ok = ok && (wd ? (f7 == 0 || f7 == 7'h20)
                                            : ((i[31:26] == 0 || i[31:26] == 6'h10) &&
                                               (rv64 || !i[25])));
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.rd_wen = 1; e.imm = ii; e.src = SRC_IMM;
                e.word = wd; e.alu = tab[f3];
                if (f3 == 5 && i[30]) e.alu = ALU_SRA;
            end
            7'h33, 7'h3b: begin
                ok = !wd || rv64;
                if (wd) ok = ok && (f3 inside {3'd0, 3'd1, 3'd5});
                ok = ok && ((f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.rd_wen = 1;
                e.src = SRC_REG; e.word = wd; e.alu = tab[f3];
                if (f7 == 7'h20) e.alu = (f3 == 0) ? ALU_SUB : ALU_SRA;
            end
            7'h0f: ok = (f3 == 0);
            7'h73: begin
                ok = (i == 32'h73) || (i == I_EBRK);
                e.ebk = (i == I_EBRK);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin e = '0; e.ill = 1'b1; end
        if (e.rd == 0) e.rd_wen = 1'b0;
        if (!rv64) e.imm[63:32] = 32'h0;
        return e;
    endfunction

    function automatic bund_t expect_of(input ent_t en, input bit rv64);
        bund_t e;
        e = ref_dec(en.inst, rv64);
        e.pc = rv64 ? en.pc : {32'h0, en.pc[31:0]};
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [13];
        int          k;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1b, 7'h33, 7'h3b,
                7'h0f, 7'h73};
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k < 13) r[6:0] = ops[k];
        if ((r[6:0] inside {7'h13, 7'h1b, 7'h33, 7'h3b}) && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if (r[6:0] == 7'h73) begin
            k = $urandom_range(0, 7);
            if (k == 0) r = I_EBRK;
            else if (k < 3) r = 32'h73;
        end
        return r;
    endfunction

    // One clock: drive at negedge, compare both DUTs with the model, then
    // advance the model at the posedge.
    task automatic step(input logic v, input logic [31:0] inst, input logic rdy,
                        input logic fl);
        bit m_rdy, acc;
        ent_t en;
        @(negedge clk);
        in_valid = v; in_inst = inst; out_ready = rdy; flush = fl;
        in_pc = {$urandom, $urandom};
        #1;
        m_rdy = (q.size() < 2) && !m_halt && !fl;
        acc   = v && m_rdy;
        chk1("in_ready64", a_rdy, m_rdy);
        chk1("in_ready32", b_rdy, m_rdy);
        chk1("out_valid64", a_ov, q.size() > 0);
        chk1("out_valid32", b_ov, q.size() > 0);
        chk1("halted64", a_halt, m_halt);
        chk1("halted32", b_halt, m_halt);
        if (q.size() > 0) begin
            chk_b("bundle64", obs_a, expect_of(q[0], 1'b1));
            chk_b("bundle32", obs_b, expect_of(q[0], 1'b0));
        end
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (acc) begin
                en.inst = inst; en.pc = in_pc;
                q.push_back(en);
                if (inst == I_EBRK) m_halt = 1'b1;
            end
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        q.delete();
        m_halt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rst_out_valid64", a_ov, 1'b0);
        chk1("rst_out_valid32", b_ov, 1'b0);
        chk1("rst_halted64", a_halt, 1'b0);
        chk1("rst_in_ready64", a_rdy, 1'b1);
        chk_b("rst_fields64", obs_a, '0);
        chk_b("rst_fields32", obs_b, '0);
    endtask

    initial begin
        do_reset();

        // addi x1,x0,5 with ready downstream
        step(1'b1, I_ADDI, 1'b1, 1'b0);
        settle();
        chk1("addi_valid", a_ov, 1'b1);
        chk64("addi_rd", 64'(a_rd), 64'd1);
        chk64("addi_rs1", 64'(a_rs1), 64'd0);
        chk64("addi_imm", a_imm, 64'd5);
        chk1("addi_rd_wen", a_rd_wen, 1'b1);
        chk64("addi_src", 64'(a_src), 64'(SRC_IMM));
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // backpressure: sub then addi fill both registers
        step(1'b1, I_SUB, 1'b0, 1'b0);
        step(1'b1, I_ADDI, 1'b0, 1'b0);
        settle();
        chk1("bp_in_ready", a_rdy, 1'b0);
        chk64("bp_sub_alu", 64'(a_alu), 64'(ALU_SUB));
        step(1'b0, 32'h0, 1'b1, 1'b0);
        settle();
        chk64("bp_addi_imm", a_imm, 64'd5);
        chk1("bp_addi_valid", a_ov, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // sd x2,8(x1)
        step(1'b1, I_SD, 1'b1, 1'b0);
        settle();
        chk1("sd_wen", a_wen, 1'b1);
        chk64("sd_size", 64'(a_size), 64'd3);
        chk64("sd_rs1", 64'(a_rs1), 64'd1);
        chk64("sd_rs2", 64'(a_rs2), 64'd2);
        chk64("sd_imm", a_imm, 64'd8);
        chk1("sd_rd_wen", a_rd_wen, 1'b0);

        // ld: legal on RV64, illegal on RV32, no halt
        step(1'b1, I_LD, 1'b1, 1'b0);
        settle();
        chk1("ld32_illegal", b_ill, 1'b1);
        chk1("ld32_rd_wen", b_rd_wen, 1'b0);
        chk1("ld32_mem_ren", b_ren, 1'b0);
        chk1("ld32_halted", b_halt, 1'b0);
        chk1("ld64_mem_ren", a_ren, 1'b1);

        // ebreak halts; following addi is refused
        step(1'b1, I_EBRK, 1'b1, 1'b0);
        settle();
        chk1("ebk_flag", a_ebk, 1'b1);
        chk1("ebk_halted", a_halt, 1'b1);
        chk1("ebk_in_ready", a_rdy, 1'b0);
        step(1'b1, I_ADDI, 1'b1, 1'b0);
        step(1'b1, I_ADDI, 1'b1, 1'b0);
        settle();
        chk1("halt_drained", a_ov, 1'b0);
        do_reset();

        // both registers full, then flush with in_valid high
        step(1'b1, I_ADDI, 1'b0, 1'b0);
        step(1'b1, I_SUB, 1'b0, 1'b0);
        step(1'b1, I_SD, 1'b0, 1'b1);
        settle();
        chk1("flush_out_valid", a_ov, 1'b0);
        flush = 1'b0;
        #1;
        chk1("flush_skid_empty", a_rdy, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            if (c % 128 == 127) begin
                do_reset();
            end else begin
                step($urandom_range(0, 4) != 0, rand_inst(), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 15) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
